// File: rtl/am9513_legacy_stack.sv
// Operand LIFO for the Am9513 legacy 9511/9512 path: byte-serial host port (LSB first)
// plus a push/pop strobe port for the legacy command shell. Entries are 64 bits.
module am9513_legacy_stack #(
    parameter int unsigned LEGACY_STACK_DEPTH = 16,
    localparam int unsigned DW = $clog2(LEGACY_STACK_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          shell_busy,
    input  logic          host_fmt64,
    input  logic          host_wr_en,
    input  logic [7:0]    host_wr_byte,
    input  logic          host_rd_en,
    output logic [7:0]    host_rd_byte,
    input  logic          shell_pop_we,
    input  logic          shell_push_we,
    input  logic [63:0]   shell_push_data,
    output logic [DW-1:0] stack_depth,
    output logic          stack_empty,
    output logic          stack_full,
    output logic [63:0]   stack_top,
    output logic          sticky_ovf,
    output logic          sticky_unf,
    output logic          sticky_busy_err
);

    localparam int unsigned AW = (LEGACY_STACK_DEPTH > 1) ? $clog2(LEGACY_STACK_DEPTH) : 1;

    logic [DW-1:0] depth_q, depth_d;
    logic [2:0]    wr_cnt_q, wr_cnt_d;
    logic [2:0]    rd_cnt_q, rd_cnt_d;
    logic          wr_w8_q, wr_w8_d;
    logic [63:0]   asm_q, asm_d;
    logic [63:0]   rd_sh_q, rd_sh_d;
    logic [7:0]    rd_byte_q, rd_byte_d;
    logic          ovf_q, ovf_d, unf_q, unf_d, busy_q, busy_d;

    logic [63:0]   mem_q [LEGACY_STACK_DEPTH];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [63:0]   mem_wdata;

    logic          empty, full;
    logic [AW-1:0] top_addr, push_addr;
    logic          shell_act, host_act, host_ok, wr_w8;
    logic [63:0]   asm_next;
    logic [5:0]    wr_bit;

    assign empty     = (depth_q == '0);
    assign full      = (depth_q == DW'(LEGACY_STACK_DEPTH));
    assign top_addr  = AW'(depth_q - DW'(1));
    assign push_addr = AW'(depth_q);
    assign shell_act = shell_pop_we | shell_push_we;
    assign host_act  = host_wr_en | host_rd_en;
    // Shell strobes win over any host access that slips past shell_busy.
    assign host_ok   = host_act & ~shell_busy & ~shell_act;
    assign wr_w8     = (wr_cnt_q == 3'd0) ? host_fmt64 : wr_w8_q;
    assign wr_bit    = {wr_cnt_q, 3'b000};

    always_comb begin
        depth_d   = depth_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        wr_w8_d   = wr_w8_q;
        asm_d     = asm_q;
        rd_sh_d   = rd_sh_q;
        rd_byte_d = rd_byte_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        busy_d    = busy_q;
        mem_we    = 1'b0;
        mem_waddr = push_addr;
        mem_wdata = shell_push_data;
        asm_next  = (wr_cnt_q == 3'd0) ? 64'h0 : asm_q;
        asm_next[wr_bit +: 8] = host_wr_byte;

        if (host_act && !host_ok) begin
            busy_d = 1'b1;
        end
        if (host_ok && host_wr_en && host_rd_en) begin
            busy_d = 1'b1;
        end

        if (shell_act) begin
            if (shell_pop_we && shell_push_we) begin
                mem_we = 1'b1;
                if (empty) begin
                    depth_d = depth_q + DW'(1);
                    unf_d   = 1'b1;
                end else begin
                    mem_waddr = top_addr;
                end
            end else if (shell_pop_we) begin
                if (empty) begin
                    unf_d = 1'b1;
                end else begin
                    depth_d = depth_q - DW'(1);
                end
            end else if (full) begin
                ovf_d = 1'b1;
            end else begin
                mem_we  = 1'b1;
                depth_d = depth_q + DW'(1);
            end
        end else if (host_ok && host_wr_en) begin
            wr_w8_d = wr_w8;
            asm_d   = asm_next;
            if (wr_cnt_q == (wr_w8 ? 3'd7 : 3'd3)) begin
                wr_cnt_d = 3'd0;
                if (full) begin
                    ovf_d = 1'b1;
                end else begin
                    mem_we    = 1'b1;
                    mem_wdata = asm_next;
                    depth_d   = depth_q + DW'(1);
                end
            end else begin
                wr_cnt_d = wr_cnt_q + 3'd1;
            end
        end else if (host_ok && host_rd_en) begin
            if (rd_cnt_q != 3'd0) begin
                rd_byte_d = rd_sh_q[7:0];
                rd_sh_d   = {8'h00, rd_sh_q[63:8]};
                rd_cnt_d  = rd_cnt_q - 3'd1;
            end else if (!empty) begin
                rd_byte_d = stack_top[7:0];
                rd_sh_d   = {8'h00, stack_top[63:8]};
                rd_cnt_d  = host_fmt64 ? 3'd7 : 3'd3;
                depth_d   = depth_q - DW'(1);
            end else begin
                rd_byte_d = 8'h00;
                unf_d     = 1'b1;
            end
        end

        if (flush) begin
            depth_d   = '0;
            wr_cnt_d  = 3'd0;
            rd_cnt_d  = 3'd0;
            wr_w8_d   = 1'b0;
            rd_byte_d = 8'h00;
            ovf_d     = 1'b0;
            unf_d     = 1'b0;
            busy_d    = 1'b0;
            mem_we    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            depth_q   <= '0;
            wr_cnt_q  <= 3'd0;
            rd_cnt_q  <= 3'd0;
            wr_w8_q   <= 1'b0;
            asm_q     <= 64'h0;
            rd_sh_q   <= 64'h0;
            rd_byte_q <= 8'h00;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            depth_q   <= depth_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            wr_w8_q   <= wr_w8_d;
            asm_q     <= asm_d;
            rd_sh_q   <= rd_sh_d;
            rd_byte_q <= rd_byte_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
            busy_q    <= busy_d;
        end
    end

    // Storage contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign stack_top       = empty ? 64'h0 : mem_q[top_addr];
    assign stack_depth     = depth_q;
    assign stack_empty     = empty;
    assign stack_full      = full;
    assign host_rd_byte    = rd_byte_q;
    assign sticky_ovf      = ovf_q;
    assign sticky_unf      = unf_q;
    assign sticky_busy_err = busy_q;

endmodule

// File: tb/tb_am9513_legacy_stack.sv
// Self-checking bench for am9513_legacy_stack: directed scenarios plus a randomized run
// against a queue-based operand/byte model.
module tb_am9513_legacy_stack;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned DW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0, shell_busy = 1'b0, host_fmt64 = 1'b0;
    logic          host_wr_en = 1'b0, host_rd_en = 1'b0;
    logic [7:0]    host_wr_byte = 8'h00;
    logic [7:0]    host_rd_byte;
    logic          shell_pop_we = 1'b0, shell_push_we = 1'b0;
    logic [63:0]   shell_push_data = 64'h0;
    logic [DW-1:0] stack_depth;
    logic          stack_empty, stack_full;
    logic [63:0]   stack_top;
    logic          sticky_ovf, sticky_unf, sticky_busy_err;

    am9513_legacy_stack #(.LEGACY_STACK_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .shell_busy(shell_busy),
        .host_fmt64(host_fmt64), .host_wr_en(host_wr_en), .host_wr_byte(host_wr_byte),
        .host_rd_en(host_rd_en), .host_rd_byte(host_rd_byte),
        .shell_pop_we(shell_pop_we), .shell_push_we(shell_push_we),
        .shell_push_data(shell_push_data), .stack_depth(stack_depth),
        .stack_empty(stack_empty), .stack_full(stack_full), .stack_top(stack_top),
        .sticky_ovf(sticky_ovf), .sticky_unf(sticky_unf), .sticky_busy_err(sticky_busy_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: operand stack, pending write bytes, pending read bytes, flags.
    logic [63:0] m_stack[$];
    logic [7:0]  m_wq[$];
    logic [7:0]  m_rq[$];
    int          m_wlen = 4;
    logic [7:0]  m_rd = 8'h00;
    bit          m_ovf = 0, m_unf = 0, m_busy = 0;

    function automatic logic [63:0] m_top();
        if (m_stack.size() == 0) return 64'h0;
        return m_stack[m_stack.size() - 1];
    endfunction

    task automatic model_reset();
        m_stack.delete(); m_wq.delete(); m_rq.delete();
        m_wlen = 4; m_rd = 8'h00; m_ovf = 0; m_unf = 0; m_busy = 0;
    endtask

    task automatic model_apply(input bit f, input bit b, input bit fmt, input bit we,
                               input logic [7:0] wb, input bit re, input bit pop,
                               input bit push, input logic [63:0] pd);
        logic [63:0] v;
        bit shell, host, ok;
        if (f) begin
            model_reset();
            return;
        end
        shell = pop || push;
        host  = we || re;
        ok    = host && !b && !shell;
        if (host && !ok) m_busy = 1;
        if (shell) begin
            if (pop && push) begin
                if (m_stack.size() == 0) begin m_stack.push_back(pd); m_unf = 1; end
                else m_stack[m_stack.size() - 1] = pd;
            end else if (pop) begin
                if (m_stack.size() == 0) m_unf = 1; else void'(m_stack.pop_back());
            end else begin
                if (m_stack.size() == DEPTH) m_ovf = 1; else m_stack.push_back(pd);
            end
        end else if (ok && we) begin
            if (re) m_busy = 1;
            if (m_wq.size() == 0) m_wlen = fmt ? 8 : 4;
            m_wq.push_back(wb);
            if (m_wq.size() == m_wlen) begin
                v = 64'h0;
                foreach (m_wq[i]) v = v | (64'(m_wq[i]) << (8 * i));
                m_wq.delete();
                if (m_stack.size() == DEPTH) m_ovf = 1; else m_stack.push_back(v);
            end
        end else if (ok && re) begin
            if (m_rq.size() == 0 && m_stack.size() != 0) begin
                v = m_stack.pop_back();
                for (int i = 0; i < (fmt ? 8 : 4); i++) m_rq.push_back(v[8*i +: 8]);
            end
            if (m_rq.size() != 0) m_rd = m_rq.pop_front();
            else begin m_rd = 8'h00; m_unf = 1; end
        end
    endtask

    task automatic cyc(input bit f, input bit b, input bit fmt, input bit we,
                       input logic [7:0] wb, input bit re, input bit pop, input bit push,
                       input logic [63:0] pd);
        flush = f; shell_busy = b; host_fmt64 = fmt; host_wr_en = we; host_wr_byte = wb;
        host_rd_en = re; shell_pop_we = pop; shell_push_we = push; shell_push_data = pd;
        model_apply(f, b, fmt, we, wb, re, pop, push, pd);
        @(posedge clk);
        #1;
        flush = 0; shell_busy = 0; host_wr_en = 0; host_rd_en = 0;
        shell_pop_we = 0; shell_push_we = 0;
    endtask

    task automatic wr(input logic [7:0] b, input bit fmt);
        cyc(0, 0, fmt, 1, b, 0, 0, 0, 64'h0);
    endtask

    task automatic rd(input bit fmt);
        cyc(0, 0, fmt, 0, 8'h00, 1, 0, 0, 64'h0);
    endtask

    task automatic do_flush();
        cyc(1, 0, 0, 0, 8'h00, 0, 0, 0, 64'h0);
    endtask

    task automatic write_op(input logic [63:0] v, input bit fmt);
        for (int i = 0; i < (fmt ? 8 : 4); i++) wr(v[8*i +: 8], fmt);
    endtask

    task automatic test_reset();
        n_cmp++;
        if (stack_depth !== '0 || stack_empty !== 1'b1 || stack_full !== 1'b0 ||
            stack_top !== 64'h0 || host_rd_byte !== 8'h00 ||
            {sticky_ovf, sticky_unf, sticky_busy_err} !== 3'b000) begin
            n_err++;
            $display("FAIL reset: depth=%0d empty=%b full=%b top=%h rd=%h flags=%b, want 0/1/0/0/0/000",
                     stack_depth, stack_empty, stack_full, stack_top, host_rd_byte,
                     {sticky_ovf, sticky_unf, sticky_busy_err});
        end
    endtask

    task automatic test_fp32_write();
        do_flush();
        wr(8'h00, 0); wr(8'h00, 0); wr(8'h80, 0); wr(8'h3F, 0);
        n_cmp++;
        if (stack_depth !== DW'(1)) begin
            n_err++; $display("FAIL fp32_depth: got %0d want 1", stack_depth);
        end
        n_cmp++;
        if (stack_top !== 64'h0000_0000_3F80_0000) begin
            n_err++; $display("FAIL fp32_top: got %h want 000000003f800000", stack_top);
        end
    endtask

    task automatic test_fp64_roundtrip();
        do_flush();
        write_op(64'h4000_0000_0000_0000, 1);
        for (int i = 0; i < 8; i++) begin
            rd(1);
            n_cmp++;
            if (host_rd_byte !== ((i == 7) ? 8'h40 : 8'h00)) begin
                n_err++;
                $display("FAIL fp64_read[%0d]: got %h want %h", i, host_rd_byte,
                         (i == 7) ? 8'h40 : 8'h00);
            end
            if (i == 0) begin
                n_cmp++;
                if (stack_depth !== '0) begin
                    n_err++; $display("FAIL fp64_pop_depth: got %0d want 0", stack_depth);
                end
            end
        end
    endtask

    task automatic test_overflow_flush();
        logic [63:0] last;
        do_flush();
        last = 64'h0;
        for (int i = 0; i < DEPTH; i++) begin
            last = 64'($urandom);
            write_op(last, 0);
        end
        write_op(64'hDEAD_BEEF, 0);
        n_cmp++;
        if (stack_depth !== DW'(DEPTH) || stack_full !== 1'b1 || sticky_ovf !== 1'b1) begin
            n_err++;
            $display("FAIL overflow: depth=%0d full=%b ovf=%b want %0d/1/1",
                     stack_depth, stack_full, sticky_ovf, DEPTH);
        end
        n_cmp++;
        if (stack_top !== last) begin
            n_err++; $display("FAIL overflow_top: got %h want %h", stack_top, last);
        end
        do_flush();
        n_cmp++;
        if (stack_depth !== '0 || sticky_ovf !== 1'b0) begin
            n_err++;
            $display("FAIL flush_clear: depth=%0d ovf=%b want 0/0", stack_depth, sticky_ovf);
        end
        rd(0);
        n_cmp++;
        if (host_rd_byte !== 8'h00 || sticky_unf !== 1'b1) begin
            n_err++;
            $display("FAIL empty_read: rd=%h unf=%b want 00/1", host_rd_byte, sticky_unf);
        end
    endtask

    task automatic test_shell_ops();
        do_flush();
        write_op(64'h1111_2222, 0);
        write_op(64'h3333_4444, 0);
        n_cmp++;
        if (stack_top !== 64'h3333_4444) begin
            n_err++; $display("FAIL shell_top_b: got %h want 33334444", stack_top);
        end
        cyc(0, 1, 0, 0, 8'h00, 0, 1, 0, 64'h0);
        n_cmp++;
        if (stack_top !== 64'h1111_2222) begin
            n_err++; $display("FAIL shell_top_a: got %h want 11112222", stack_top);
        end
        cyc(0, 1, 0, 0, 8'h00, 0, 1, 0, 64'h0);
        cyc(0, 1, 0, 0, 8'h00, 0, 0, 1, 64'h1234);
        n_cmp++;
        if (stack_depth !== DW'(1) || stack_top !== 64'h1234) begin
            n_err++;
            $display("FAIL shell_push: depth=%0d top=%h want 1/1234", stack_depth, stack_top);
        end
        cyc(0, 1, 0, 0, 8'h00, 0, 1, 1, 64'hCAFE_F00D_0000_5678);
        n_cmp++;
        if (stack_depth !== DW'(1) || stack_top !== 64'hCAFE_F00D_0000_5678) begin
            n_err++;
            $display("FAIL shell_replace: depth=%0d top=%h want 1/cafef00d00005678",
                     stack_depth, stack_top);
        end
        n_cmp++;
        if (sticky_unf !== 1'b0) begin
            n_err++; $display("FAIL shell_no_unf: got %b want 0", sticky_unf);
        end
        do_flush();
        cyc(0, 0, 0, 0, 8'h00, 0, 1, 1, 64'h77);
        n_cmp++;
        if (stack_depth !== DW'(1) || stack_top !== 64'h77 || sticky_unf !== 1'b1) begin
            n_err++;
            $display("FAIL shell_replace_empty: depth=%0d top=%h unf=%b want 1/77/1",
                     stack_depth, stack_top, sticky_unf);
        end
    endtask

    task automatic test_busy();
        do_flush();
        wr(8'h11, 0);
        cyc(0, 1, 0, 1, 8'hEE, 0, 0, 0, 64'h0);
        n_cmp++;
        if (sticky_busy_err !== 1'b1 || stack_depth !== '0) begin
            n_err++;
            $display("FAIL busy_reject: err=%b depth=%0d want 1/0", sticky_busy_err, stack_depth);
        end
        wr(8'h22, 0); wr(8'h33, 0); wr(8'h44, 0);
        n_cmp++;
        if (stack_depth !== DW'(1) || stack_top !== 64'h4433_2211) begin
            n_err++;
            $display("FAIL busy_resume: depth=%0d top=%h want 1/44332211",
                     stack_depth, stack_top);
        end
    endtask

    task automatic test_reset_mid_operand();
        do_flush();
        wr(8'hAA, 0); wr(8'hBB, 0);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (stack_depth !== '0 || stack_empty !== 1'b1 || stack_top !== 64'h0 ||
            host_rd_byte !== 8'h00 || {sticky_ovf, sticky_unf, sticky_busy_err} !== 3'b000) begin
            n_err++;
            $display("FAIL reset_mid: depth=%0d empty=%b top=%h rd=%h flags=%b want 0/1/0/00/000",
                     stack_depth, stack_empty, stack_top, host_rd_byte,
                     {sticky_ovf, sticky_unf, sticky_busy_err});
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr(8'h01, 0); wr(8'h02, 0); wr(8'h03, 0); wr(8'h04, 0);
        n_cmp++;
        if (stack_depth !== DW'(1) || stack_top !== 64'h0403_0201) begin
            n_err++;
            $display("FAIL reset_fresh: depth=%0d top=%h want 1/04030201", stack_depth, stack_top);
        end
    endtask

    task automatic test_random();
        bit f, b, fmt, we, re, pop, push;
        do_flush();
        for (int i = 0; i < 1500; i++) begin
            f    = ($urandom_range(0, 199) == 0);
            b    = ($urandom_range(0, 9) == 0);
            fmt  = 1'($urandom);
            we   = ($urandom_range(0, 99) < 45);
            re   = ($urandom_range(0, 99) < 30);
            pop  = ($urandom_range(0, 99) < 6);
            push = ($urandom_range(0, 99) < 6);
            cyc(f, b, fmt, we, 8'($urandom), re, pop, push, {$urandom, $urandom});
            n_cmp++;
            if (stack_depth !== DW'(m_stack.size()) || stack_empty !== (m_stack.size() == 0) ||
                stack_full !== (m_stack.size() == DEPTH)) begin
                n_err++;
                $display("FAIL rand_depth[%0d]: got %0d/%b/%b want %0d", i, stack_depth,
                         stack_empty, stack_full, m_stack.size());
            end
            n_cmp++;
            if (stack_top !== m_top()) begin
                n_err++; $display("FAIL rand_top[%0d]: got %h want %h", i, stack_top, m_top());
            end
            n_cmp++;
            if (host_rd_byte !== m_rd) begin
                n_err++; $display("FAIL rand_rd[%0d]: got %h want %h", i, host_rd_byte, m_rd);
            end
            n_cmp++;
            if ({sticky_ovf, sticky_unf, sticky_busy_err} !== {m_ovf, m_unf, m_busy}) begin
                n_err++;
                $display("FAIL rand_flags[%0d]: got %b want %b", i,
                         {sticky_ovf, sticky_unf, sticky_busy_err}, {m_ovf, m_unf, m_busy});
            end
        end
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        test_fp32_write();
        test_fp64_roundtrip();
        test_overflow_flush();
        test_shell_ops();
        test_busy();
        test_reset_mid_operand();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/am9513_legacy_stack.md
Name: am9513_legacy_stack

Overview:
Operand LIFO for the Am9513 legacy 9511/9512 compatibility path. The host side writes and reads operands byte-serially, LSB first, in the legacy data-port style. The compute side exposes depth, empty, full and top-of-stack to the legacy command shell, and accepts pop/push strobes from it. Entries are stored 64 bits wide; fp32 operands are zero-extended.

Parameters:
LEGACY_STACK_DEPTH, 16, number of 64-bit entries (>=2).

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
flush  in  1  sync clear: depth, byte counters, sticky flags to 0
shell_busy  in  1  legacy shell executing; host accesses rejected while high
host_fmt64  in  1  1 = 8-byte operands, 0 = 4-byte; sampled at first byte of each operand
host_wr_en  in  1  host writes one byte
host_wr_byte  in  8  write data
host_rd_en  in  1  host reads one byte
host_rd_byte  out  8  read data, registered, valid the cycle after host_rd_en
shell_pop_we  in  1  pop top entry
shell_push_we  in  1  push shell_push_data
shell_push_data  in  64  result from shell
stack_depth  out  $clog2(LEGACY_STACK_DEPTH+1)  entry count
stack_empty  out  1  depth==0
stack_full  out  1  depth==LEGACY_STACK_DEPTH
stack_top  out  64  mem[depth-1]; 0 when empty (combinational)
sticky_ovf  out  1  push attempted while full
sticky_unf  out  1  pop/read attempted while empty
sticky_busy_err  out  1  host access attempted while shell_busy

Behaviour:
- Reset and flush:
  - Depth = 0.
  - wr_cnt, rd_cnt = 0.
  - host_rd_byte = 0.
  - All sticky flags = 0.
  - Width register = 4 bytes.
  - Storage contents are don't-care.
  - flush has priority over every other input in its cycle.
- Host write (shell_busy=0):
  - On host_wr_en with wr_cnt==0, latch width_w = host_fmt64 ? 8 : 4.
  - Place the byte at position wr_cnt of the assembly register (LSB first), then increment wr_cnt.
  - On the final byte (wr_cnt==width_w-1): push the assembled value, zero-extended to 64 bits, and set wr_cnt = 0.
  - If the stack is full at that push: drop the operand, set sticky_ovf, depth unchanged.
- Host read (shell_busy=0):
  - host_rd_en with rd_cnt==0 and non-empty:
    - latch top into the read shift register; width_r = host_fmt64 ? 8 : 4;
    - pop (depth-1) the same cycle;
    - next cycle host_rd_byte = byte0; rd_cnt = width_r-1.
  - host_rd_en with rd_cnt>0: host_rd_byte = next byte; rd_cnt decrements.
  - host_rd_en with rd_cnt==0 and empty: host_rd_byte = 0, set sticky_unf.
  - host_rd_byte holds its value between reads.
- Simultaneous host_wr_en and host_rd_en: the write is processed, the read is ignored, and sticky_busy_err is set.
- Any host_wr_en or host_rd_en while shell_busy=1: ignored, sticky_busy_err set, counters unchanged.
- Shell side (acted on in any cycle, independent of shell_busy):
  - pop when non-empty: depth-1.
  - pop when empty: set sticky_unf, depth unchanged.
  - push when not full: mem[depth] = data, depth+1.
  - push when full: set sticky_ovf, drop.
  - pop and push in the same cycle: replace the top; depth unchanged. If empty, this acts as a plain push and sticky_unf is set.
- Shell and host events cannot collide, because host access is gated by shell_busy. If they do anyway, the shell wins and the host access is dropped with sticky_busy_err set.
- stack_top, stack_depth, stack_empty and stack_full reflect registered state. A pop/push is visible in these outputs the cycle after the strobe.
- No wrap-around: depth saturates at 0 and at LEGACY_STACK_DEPTH.
- Sticky flags clear only on reset or flush.
- Reset asserted mid-operand: the partial assembly and partial read are discarded.

Test Plan:
- Write 4 bytes 00,00,80,3F with fmt64=0 -> depth=1, stack_top=0x000000003F800000.
- Write 8 bytes of 0x4000000000000000 (fmt64=1), then 8 reads -> host_rd_byte sequence 00×7,40, one cycle after each read; depth returns to 0 after the first read.
- Fill 16 operands, write a 17th -> depth stays 16, stack_full=1, sticky_ovf=1, stack_top unchanged; read with depth 0 after flush -> host_rd_byte=0, sticky_unf=1.
- Push A then B from the host; assert shell_pop_we 2 cycles then shell_push_we with 0x1234 -> stack_top=B then A, final depth=1, top=0x1234; pop+push in one cycle with depth 1 -> depth 1, top replaced.
- host_wr_en with shell_busy=1 -> sticky_busy_err=1, wr_cnt unchanged; the next 4 writes after busy drops complete exactly one operand.
- Assert rst_n low after 2 of 4 bytes are written -> all outputs are reset values; a fresh 4-byte write then yields depth=1 with only the new bytes.
